mem_access_unit: RTL

- MEM-stage data-memory access controller, directly downstream of the EX/MEM pipeline register.
- Consumes the registered PC, ALU result (effective address), rs2 value (store data) and memory control bits.
- Drives a single-port data-memory/cache interface with a read/write-until-resp handshake, and asserts pipeline stall while an access is outstanding.
- Returns the aligned, sign- or zero-extended load value to the MEM/WB register.

---
 rtl/mem_access_unit.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access controller. Issues one registered
// read/write per memory instruction, stalls the pipeline until resp, extends loads.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MEM_pc,
    input  logic [31:0] MEM_alu_out,
    input  logic [31:0] MEM_rs2_out,
    input  logic        MEM_valid,
    input  logic        MEM_mem_read,
    input  logic        MEM_mem_write,
    input  logic [2:0]  MEM_funct3,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [3:0]  dmem_byte_enable,
    output logic [31:0] dmem_wdata,
    output logic        mem_stall,
    output logic [31:0] MEM_rdata,
    output logic        mem_fault,
    output logic [31:0] mem_fault_pc,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          req, bad, misaligned, illegal_f3, issue, timeout;
    logic          rd_q, rd_d, wr_q, wr_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, pc_q, pc_d;
    logic [31:0]   rdata_q, rdata_d, fault_pc_q, fault_pc_d;
    logic [3:0]    be_q, be_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    sel_b;
    logic [15:0]   sel_h;
    logic [31:0]   load_val;

    // Handshake: dmem_read/dmem_write rise on entry to ACCESS and, together with
    // address, byte enables and wdata, stay stable until dmem_resp is seen high.
    assign req        = MEM_valid & (MEM_mem_read | MEM_mem_write);
    assign illegal_f3 = (MEM_funct3 == 3'b011) || (MEM_funct3 == 3'b110) || (MEM_funct3 == 3'b111);
    assign misaligned = ((MEM_funct3[1:0] == 2'b10) && (MEM_alu_out[1:0] != 2'b00)) ||
                        ((MEM_funct3[1:0] == 2'b01) && MEM_alu_out[0]);
    assign bad        = misaligned | illegal_f3;
    assign issue      = (state_q == IDLE) && req && !bad;
    assign timeout    = (state_q == ACCESS) && !dmem_resp && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (issue) state_d = ACCESS;
            ACCESS:  if (dmem_resp || timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        mem_fault = 1'b0;
        if (reset) begin
            case (state_q)
                IDLE: begin
                    mem_stall = issue;
                    mem_fault = req & bad;
                end
                ACCESS: begin
                    mem_stall = 1'b1;
                    mem_fault = timeout;
                end
                default: ;
            endcase
        end
    end

    assign dmem_read        = rd_q;
    assign dmem_write       = wr_q;
    assign dmem_address     = addr_q;
    assign dmem_byte_enable = be_q;
    assign dmem_wdata       = wdata_q;
    assign MEM_rdata        = rdata_q;
    assign mem_fault_pc     = fault_pc_q;
    assign dbg_state        = state_q;

    always_comb begin
        case (off_q)
            2'd0:    sel_b = dmem_rdata[7:0];
            2'd1:    sel_b = dmem_rdata[15:8];
            2'd2:    sel_b = dmem_rdata[23:16];
            default: sel_b = dmem_rdata[31:24];
        endcase
        sel_h = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{sel_b[7]}}, sel_b};
            3'b100:  load_val = {24'd0, sel_b};
            3'b001:  load_val = {{16{sel_h[15]}}, sel_h};
            3'b101:  load_val = {16'd0, sel_h};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        f3_d       = f3_q;
        off_d      = off_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        fault_pc_d = fault_pc_q;
        if (issue) begin
            rd_d   = MEM_mem_read;
            wr_d   = !MEM_mem_read;
            addr_d = {MEM_alu_out[31:2], 2'b00};
            off_d  = MEM_alu_out[1:0];
            f3_d   = MEM_funct3;
            pc_d   = MEM_pc;
            cnt_d  = '0;
            if (MEM_mem_read) begin
                be_d    = 4'b1111;
                wdata_d = MEM_rs2_out;
            end else begin
                case (MEM_funct3[1:0])
                    2'b00: begin
                        be_d    = 4'b0001 << MEM_alu_out[1:0];
                        wdata_d = {4{MEM_rs2_out[7:0]}};
                    end
                    2'b01: begin
                        be_d    = 4'b0011 << MEM_alu_out[1:0];
                        wdata_d = {2{MEM_rs2_out[15:0]}};
                    end
                    default: begin
                        be_d    = 4'b1111;
                        wdata_d = MEM_rs2_out;
                    end
                endcase
            end
        end
        if ((state_q == IDLE) && req && bad) fault_pc_d = MEM_pc;
        if (state_q == ACCESS) begin
            cnt_d = cnt_q + CW'(1);
            if (dmem_resp) begin
                rd_d    = 1'b0;
                wr_d    = 1'b0;
                rdata_d = load_val;
            end else if (timeout) begin
                rd_d       = 1'b0;
                wr_d       = 1'b0;
                rdata_d    = '0;
                fault_pc_d = pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            pc_q       <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            fault_pc_q <= '0;
        end else begin
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            f3_q       <= f3_d;
            off_q      <= off_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            fault_pc_q <= fault_pc_d;
        end
    end
endmodule
